// File: rtl/mux_share_arbiter_pkg.sv
// ============================================================================
// Module  : mux_share_arbiter_pkg
// Brief   : Shared state encodings and width helpers for the mux-share
//           arbiter and its winner-pick sub-block.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package mux_share_arbiter_pkg;

    // Arbiter FSM encodings.
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_OWN  = 1'b1;

    // Ceiling log2, usable in parameter and localparam expressions.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << r) < value) begin
                r = r + 1;
            end
        end
        return r;
    endfunction

    // Index width for an N-entry select, never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n < 2) ? 1 : clog2(n);
    endfunction

endpackage : mux_share_arbiter_pkg

`default_nettype wire

// File: rtl/mux_share_pick.sv
// ============================================================================
// Module  : mux_share_pick
// Brief   : Combinational winner pick. Scans req & mask starting at base and
//           wrapping round; returns the first hit and a found flag. Fixed
//           priority is obtained by tying base to zero.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mux_share_pick
    import mux_share_arbiter_pkg::*;
#(
    parameter int N  = 4,
    parameter int SW = idx_w(N)
) (
    input  logic [N-1:0]  req,
    input  logic [N-1:0]  mask,
    input  logic [SW-1:0] base,
    output logic [SW-1:0] winner,
    output logic          found
);

    logic [N-1:0]  cand;
    logic [SW-1:0] idx;

    assign cand = req & mask;

    // Walk offsets from farthest to nearest so the nearest hit to base is
    // the last one written and therefore wins.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = '0;
        for (int off = N - 1; off >= 0; off--) begin
            idx = SW'((int'(base) + off) % N);
            if (cand[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

endmodule : mux_share_pick

`default_nettype wire

// File: rtl/mux_share_arbiter.sv
// ============================================================================
// Module  : mux_share_arbiter
// Brief   : Shares one registered N:1 W-bit mux path between N requesters
//           with a req/gnt handshake. The owner keeps the grant while it
//           holds req, but is forced off after MAX_HOLD cycles when others
//           are waiting. Handover between owners has no idle bubble.
// Options : MUX_SHARE_ARB_FIXED_PRIO_EN - lowest-index requester wins
//           instead of round-robin; pointer register removed.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mux_share_arbiter
    import mux_share_arbiter_pkg::*;
#(
    parameter int N        = 4,
    parameter int W        = 2,
    parameter int MAX_HOLD = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N-1:0]         req,
    input  logic [N*W-1:0]       din,
    output logic [N-1:0]         gnt,
    output logic [idx_w(N)-1:0]  sel,
    output logic                 busy,
    output logic [W-1:0]         dout,
    output logic                 dout_valid
);

    localparam int SW = idx_w(N);
    localparam int HW = clog2(MAX_HOLD + 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [0:0]    state;
    logic [HW-1:0] hold;

    logic [0:0]    state_nxt;
    logic [N-1:0]  gnt_nxt;
    logic [SW-1:0] sel_nxt;
    logic          busy_nxt;
    logic [HW-1:0] hold_nxt;
    logic          grant_new;

    // ------------------------------------------------------------------
    // Arbitration inputs
    // ------------------------------------------------------------------
    logic          owner_req;
    logic          others_pending;
    logic          hold_max;
    logic [N-1:0]  pick_mask;
    logic [SW-1:0] pick_base;
    logic [SW-1:0] win;
    logic          found;

    // The owner's own req is still high during a forced release, so it must
    // be masked; when the owner dropped req the mask is harmless, and in
    // IDLE gnt is zero so every requester is eligible.
    assign owner_req      = |(req & gnt);
    assign others_pending = |(req & ~gnt);
    assign hold_max       = (hold >= HW'(MAX_HOLD));
    assign pick_mask      = ~gnt;

    mux_share_pick #(
        .N  (N),
        .SW (SW)
    ) u_pick (
        .req    (req),
        .mask   (pick_mask),
        .base   (pick_base),
        .winner (win),
        .found  (found)
    );

`ifdef MUX_SHARE_ARB_FIXED_PRIO_EN
    // Scanning from index 0 gives lowest-index priority.
    assign pick_base = '0;
`else
    logic [SW-1:0] ptr;

    // Round-robin pointer moves to the slot after each new winner.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (grant_new) begin
            ptr <= (win == SW'(N - 1)) ? '0 : (win + SW'(1));
        end
    end

    assign pick_base = ptr;
`endif

    // Next-state decision: start, keep, hand over, or go idle.
    always_comb begin
        state_nxt = state;
        gnt_nxt   = gnt;
        sel_nxt   = sel;
        busy_nxt  = busy;
        hold_nxt  = hold;
        grant_new = 1'b0;

        case (state)
            ST_IDLE: begin
                if (found) begin
                    grant_new = 1'b1;
                end
            end

            ST_OWN: begin
                // A dropped owner takes precedence over expiry, so a
                // simultaneous drop and expiry is just a normal drop.
                if (!owner_req || (others_pending && hold_max)) begin
                    if (found) begin
                        grant_new = 1'b1;
                    end else begin
                        state_nxt = ST_IDLE;
                        gnt_nxt   = '0;
                        sel_nxt   = '0;
                        busy_nxt  = 1'b0;
                        hold_nxt  = '0;
                    end
                end else if (!hold_max) begin
                    hold_nxt = hold + HW'(1);
                end
            end

            default: begin
                state_nxt = ST_IDLE;
                gnt_nxt   = '0;
                sel_nxt   = '0;
                busy_nxt  = 1'b0;
                hold_nxt  = '0;
            end
        endcase

        if (grant_new) begin
            state_nxt = ST_OWN;
            gnt_nxt   = N'(1) << win;
            sel_nxt   = win;
            busy_nxt  = 1'b1;
            hold_nxt  = HW'(1);
        end
    end

    // Grant-side registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            gnt   <= '0;
            sel   <= '0;
            busy  <= 1'b0;
            hold  <= '0;
        end else begin
            state <= state_nxt;
            gnt   <= gnt_nxt;
            sel   <= sel_nxt;
            busy  <= busy_nxt;
            hold  <= hold_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Data path: one cycle behind the grant
    // ------------------------------------------------------------------
    logic [W-1:0] din_arr [N];

    for (genvar i = 0; i < N; i++) begin : g_unpack
        assign din_arr[i] = din[i*W +: W];
    end

    // Capture the owner's data while busy; dout holds when the grant ends.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout       <= '0;
            dout_valid <= 1'b0;
        end else begin
            if (busy) begin
                dout <= din_arr[sel];
            end
            dout_valid <= busy;
        end
    end

endmodule : mux_share_arbiter

`default_nettype wire

// File: tb/tb_mux_share_arbiter.sv
// ============================================================================
// Module  : tb_mux_share_arbiter
// Brief   : Self-checking bench for mux_share_arbiter (N=4, W=2, MAX_HOLD=8)
//           using a per-cycle vector table plus hand-written sequences for
//           asynchronous reset and forced release.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mux_share_arbiter;

    localparam int N        = 4;
    localparam int W        = 2;
    localparam int MAX_HOLD = 8;

    logic           clk;
    logic           rst_n;
    logic [N-1:0]   req;
    logic [N*W-1:0] din;
    logic [N-1:0]   gnt;
    logic [1:0]     sel;
    logic           busy;
    logic [W-1:0]   dout;
    logic           dout_valid;

    int checks;
    int errors;

    mux_share_arbiter #(
        .N        (N),
        .W        (W),
        .MAX_HOLD (MAX_HOLD)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .din        (din),
        .gnt        (gnt),
        .sel        (sel),
        .busy       (busy),
        .dout       (dout),
        .dout_valid (dout_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] req;
        logic [3:0] gnt;
        logic [1:0] sel;
        logic       busy;
        logic [1:0] dout;
        logic       dv;
    } vec_t;

    vec_t tbl [23];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        req    = '0;
        // r3=00, r2=11, r1=10, r0=01
        din    = {2'b00, 2'b11, 2'b10, 2'b01};

        // Per-cycle vectors: req applied before the edge, outputs after it.
        //            req      gnt      sel   busy  dout   dv
        tbl[0]  = '{4'b0000, 4'b0000, 2'd0, 1'b0, 2'b00, 1'b0};
        tbl[1]  = '{4'b0000, 4'b0000, 2'd0, 1'b0, 2'b00, 1'b0};
        tbl[2]  = '{4'b0000, 4'b0000, 2'd0, 1'b0, 2'b00, 1'b0};
        tbl[3]  = '{4'b0000, 4'b0000, 2'd0, 1'b0, 2'b00, 1'b0};
        tbl[4]  = '{4'b0000, 4'b0000, 2'd0, 1'b0, 2'b00, 1'b0};
        // round-robin 0,1,2,3,0 with no idle cycle between owners
        tbl[5]  = '{4'b1111, 4'b0001, 2'd0, 1'b1, 2'b00, 1'b0};
        tbl[6]  = '{4'b1111, 4'b0001, 2'd0, 1'b1, 2'b01, 1'b1};
        tbl[7]  = '{4'b1110, 4'b0010, 2'd1, 1'b1, 2'b01, 1'b1};
        tbl[8]  = '{4'b1110, 4'b0010, 2'd1, 1'b1, 2'b10, 1'b1};
        tbl[9]  = '{4'b1101, 4'b0100, 2'd2, 1'b1, 2'b10, 1'b1};
        tbl[10] = '{4'b1101, 4'b0100, 2'd2, 1'b1, 2'b11, 1'b1};
        tbl[11] = '{4'b1011, 4'b1000, 2'd3, 1'b1, 2'b11, 1'b1};
        tbl[12] = '{4'b1011, 4'b1000, 2'd3, 1'b1, 2'b00, 1'b1};
        tbl[13] = '{4'b0111, 4'b0001, 2'd0, 1'b1, 2'b00, 1'b1};
        tbl[14] = '{4'b0111, 4'b0001, 2'd0, 1'b1, 2'b01, 1'b1};
        // owner drops, nobody else: idle at once, valid drops one edge later
        tbl[15] = '{4'b0000, 4'b0000, 2'd0, 1'b0, 2'b01, 1'b1};
        tbl[16] = '{4'b0000, 4'b0000, 2'd0, 1'b0, 2'b01, 1'b0};
        // single requester 2, din[2]=11
        tbl[17] = '{4'b0100, 4'b0100, 2'd2, 1'b1, 2'b01, 1'b0};
        tbl[18] = '{4'b0100, 4'b0100, 2'd2, 1'b1, 2'b11, 1'b1};
        tbl[19] = '{4'b0000, 4'b0000, 2'd0, 1'b0, 2'b11, 1'b1};
        tbl[20] = '{4'b0000, 4'b0000, 2'd0, 1'b0, 2'b11, 1'b0};
        tbl[21] = '{4'b0000, 4'b0000, 2'd0, 1'b0, 2'b11, 1'b0};
        tbl[22] = '{4'b0000, 4'b0000, 2'd0, 1'b0, 2'b11, 1'b0};

        repeat (2) @(posedge clk);
        #1;
        chk("rst_gnt",  32'(gnt),        32'h0);
        chk("rst_busy", 32'(busy),       32'h0);
        chk("rst_dv",   32'(dout_valid), 32'h0);
        chk("rst_dout", 32'(dout),       32'h0);
        rst_n = 1'b1;

        for (int i = 0; i < 23; i++) begin
            req = tbl[i].req;
            step();
            chk($sformatf("v%0d_gnt", i),  32'(gnt),        32'(tbl[i].gnt));
            chk($sformatf("v%0d_sel", i),  32'(sel),        32'(tbl[i].sel));
            chk($sformatf("v%0d_busy", i), 32'(busy),       32'(tbl[i].busy));
            chk($sformatf("v%0d_dout", i), 32'(dout),       32'(tbl[i].dout));
            chk($sformatf("v%0d_dv", i),   32'(dout_valid), 32'(tbl[i].dv));
        end

        // Asynchronous reset while requester 1 owns the path.
        req = 4'b0010;
        step();
        chk("pre_rst_gnt", 32'(gnt), 32'h2);
        step();
        chk("pre_rst_dv", 32'(dout_valid), 32'h1);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_gnt",  32'(gnt),        32'h0);
        chk("arst_busy", 32'(busy),       32'h0);
        chk("arst_dv",   32'(dout_valid), 32'h0);
        chk("arst_dout", 32'(dout),       32'h0);
        req = 4'b1010;
        step();
        chk("in_rst_gnt", 32'(gnt), 32'h0);
        #1 rst_n = 1'b1;
        step();
        chk("post_rst_gnt", 32'(gnt), 32'h2);
        chk("post_rst_sel", 32'(sel), 32'h1);

        // Fresh reset, then starvation: req0 held, req3 waiting.
        req = 4'b0000;
        #1 rst_n = 1'b0;
        step();
        #1 rst_n = 1'b1;
        req = 4'b1001;
        for (int k = 1; k <= MAX_HOLD; k++) begin
            step();
            chk($sformatf("own0_c%0d", k), 32'(gnt), 32'h1);
        end
        step();
        chk("forced_gnt",  32'(gnt),  32'h8);
        chk("forced_sel",  32'(sel),  32'h3);
        chk("forced_busy", 32'(busy), 32'h1);
        chk("forced_dout", 32'(dout), 32'h1);
        step();
        chk("own3_gnt",  32'(gnt),  32'h8);
        chk("own3_dout", 32'(dout), 32'h0);

        // Everybody leaves.
        req = 4'b0000;
        step();
        chk("drop_busy", 32'(busy),       32'h0);
        chk("drop_gnt",  32'(gnt),        32'h0);
        chk("drop_dv",   32'(dout_valid), 32'h1);
        step();
        chk("drop_dv2",  32'(dout_valid), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_mux_share_arbiter

`default_nettype wire
